// File: rtl/text_cell_writer8x8.sv
// Command-driven writer for the 84x64 text cell RAM: cursor, attribute and a full-array clear.
// Define TEXT_WRITER_CTRL_CHARS_EN to interpret CR/LF/BS in PUT_CHAR as cursor moves.
`timescale 1ns/1ps

module text_cell_writer8x8 #(
    parameter logic [7:0] CLEAR_CHAR = 8'h20,
    parameter logic [7:0] RESET_ATTR = 8'hF0
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [1:0]  i_cmd,
    input  logic [15:0] i_cmd_data,
    output logic        o_cell_we,
    output logic [12:0] o_cell_addr,
    output logic [15:0] o_cell_data,
    output logic [6:0]  o_cursor_col,
    output logic [5:0]  o_cursor_row,
    output logic        o_busy
);

    localparam logic [1:0]  CmdSetCursor = 2'd0;
    localparam logic [1:0]  CmdSetAttr   = 2'd1;
    localparam logic [1:0]  CmdPutChar   = 2'd2;
    localparam logic [1:0]  CmdClear     = 2'd3;
    localparam logic [6:0]  LastCol      = 7'd83;
    localparam logic [12:0] LastAddr     = {7'd83, 6'd63};

    typedef enum logic {StIdle, StClear} state_e;

    state_e      state_q;
    logic [7:0]  attr_q;
    logic [6:0]  col_q;
    logic [5:0]  row_q;
    logic        cell_we_q;
    logic [12:0] cell_addr_q;
    logic [15:0] cell_data_q;
    logic        busy_q;
    logic        ready_q;

    logic [6:0]  set_col;
    logic [6:0]  adv_col;
    logic [5:0]  adv_row;
    logic [7:0]  char_in;
    logic        ctrl_char;
    logic [1:0]  cmd_data_unused;

    assign char_in         = i_cmd_data[7:0];
    assign cmd_data_unused = i_cmd_data[15:14];

`ifdef TEXT_WRITER_CTRL_CHARS_EN
    assign ctrl_char = (char_in == 8'h0D) || (char_in == 8'h0A) || (char_in == 8'h08);
`else
    assign ctrl_char = 1'b0;
`endif

    always_comb begin
        set_col = (i_cmd_data[6:0] > LastCol) ? LastCol : i_cmd_data[6:0];
        adv_col = col_q + 7'd1;
        adv_row = row_q;
        // Row wraps 63 -> 0 by natural 6-bit overflow, giving the (83,63) -> (0,0) wrap.
        if (col_q == LastCol) begin
            adv_col = 7'd0;
            adv_row = row_q + 6'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q     <= StIdle;
            attr_q      <= RESET_ATTR;
            col_q       <= 7'd0;
            row_q       <= 6'd0;
            cell_we_q   <= 1'b0;
            cell_addr_q <= 13'd0;
            cell_data_q <= 16'd0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            cell_we_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (i_cmd_valid && ready_q) begin
                        case (i_cmd)
                            CmdSetCursor: begin
                                col_q <= set_col;
                                row_q <= i_cmd_data[13:8];
                            end
                            CmdSetAttr: attr_q <= char_in;
                            CmdPutChar: begin
                                if (ctrl_char) begin
                                    case (char_in)
                                        8'h0D: col_q <= 7'd0;
                                        8'h0A: begin
                                            col_q <= 7'd0;
                                            row_q <= row_q + 6'd1;
                                        end
                                        default: if (col_q != 7'd0) col_q <= col_q - 7'd1;
                                    endcase
                                end else begin
                                    cell_we_q   <= 1'b1;
                                    cell_addr_q <= {col_q, row_q};
                                    cell_data_q <= {attr_q, char_in};
                                    col_q       <= adv_col;
                                    row_q       <= adv_row;
                                end
                            end
                            CmdClear: begin
                                state_q     <= StClear;
                                busy_q      <= 1'b1;
                                ready_q     <= 1'b0;
                                cell_we_q   <= 1'b1;
                                cell_addr_q <= 13'd0;
                                cell_data_q <= {attr_q, CLEAR_CHAR};
                            end
                            default: ;
                        endcase
                    end
                end
                StClear: begin
                    // Row is the low address field, so row-inner order is a plain increment.
                    if (cell_addr_q == LastAddr) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        col_q   <= 7'd0;
                        row_q   <= 6'd0;
                    end else begin
                        cell_we_q   <= 1'b1;
                        cell_addr_q <= cell_addr_q + 13'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_cmd_ready  = ready_q;
    assign o_busy       = busy_q;
    assign o_cell_we    = cell_we_q;
    assign o_cell_addr  = cell_addr_q;
    assign o_cell_data  = cell_data_q;
    assign o_cursor_col = col_q;
    assign o_cursor_row = row_q;

endmodule

// File: tb/tb_text_cell_writer8x8.sv
// Bench for text_cell_writer8x8: directed vector table, clear/reset sequences, random vs model.
`timescale 1ns/1ps

module tb_text_cell_writer8x8;

    logic        i_clk = 1'b0;
    logic        i_nrst;
    logic        i_cmd_valid;
    logic [1:0]  i_cmd;
    logic [15:0] i_cmd_data;
    logic        o_cmd_ready;
    logic        o_cell_we;
    logic [12:0] o_cell_addr;
    logic [15:0] o_cell_data;
    logic [6:0]  o_cursor_col;
    logic [5:0]  o_cursor_row;
    logic        o_busy;

    text_cell_writer8x8 dut (
        .i_clk        (i_clk),
        .i_nrst       (i_nrst),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .i_cmd        (i_cmd),
        .i_cmd_data   (i_cmd_data),
        .o_cell_we    (o_cell_we),
        .o_cell_addr  (o_cell_addr),
        .o_cell_data  (o_cell_data),
        .o_cursor_col (o_cursor_col),
        .o_cursor_row (o_cursor_row),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_we"},    32'(o_cell_we),    0);
        check({tag, "_addr"},  32'(o_cell_addr),  0);
        check({tag, "_data"},  32'(o_cell_data),  0);
        check({tag, "_ready"}, 32'(o_cmd_ready),  1);
        check({tag, "_busy"},  32'(o_busy),       0);
        check({tag, "_col"},   32'(o_cursor_col), 0);
        check({tag, "_row"},   32'(o_cursor_row), 0);
    endtask

    task automatic do_reset(input string tag);
        i_cmd_valid = 1'b0;
        i_nrst      = 1'b0;
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        check_reset_values(tag);
        i_nrst = 1'b1;
    endtask

    task automatic issue(input logic [1:0] cmd, input logic [15:0] data);
        i_cmd_valid = 1'b1;
        i_cmd       = cmd;
        i_cmd_data  = data;
        tick();
        i_cmd_valid = 1'b0;
    endtask

    // Reference model: cursor as a linear row-major position, cell address as col*64+row.
    int          m_col, m_row;
    logic [7:0]  m_attr;
    logic        m_we;
    logic [12:0] m_addr;
    logic [15:0] m_data;

    function automatic bit is_ctrl(input logic [7:0] c);
`ifdef TEXT_WRITER_CTRL_CHARS_EN
        return (c == 8'h0D) || (c == 8'h0A) || (c == 8'h08);
`else
        return (c == 8'hFF) && 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_col = 0; m_row = 0; m_attr = 8'hF0; m_we = 0; m_addr = '0; m_data = '0;
    endtask

    task automatic model_apply(input logic v, input logic [1:0] c, input logic [15:0] d);
        int idx;
        int a;
        m_we = 1'b0;
        if (v) begin
            case (c)
                2'd0: begin
                    m_col = int'(d[6:0]);
                    if (m_col > 83) m_col = 83;
                    m_row = int'(d[13:8]);
                end
                2'd1: m_attr = d[7:0];
                2'd2: begin
                    if (is_ctrl(d[7:0])) begin
                        if (d[7:0] == 8'h0D) m_col = 0;
                        else if (d[7:0] == 8'h0A) begin
                            m_col = 0;
                            m_row = (m_row + 1) % 64;
                        end else if (m_col > 0) m_col = m_col - 1;
                    end else begin
                        m_we   = 1'b1;
                        a      = m_col * 64 + m_row;
                        m_addr = a[12:0];
                        m_data = {m_attr, d[7:0]};
                        idx    = (m_row * 84 + m_col + 1) % (84 * 64);
                        m_col  = idx % 84;
                        m_row  = idx / 84;
                    end
                end
                default: ;
            endcase
        end
    endtask

    typedef struct {
        logic [1:0]  cmd;
        logic [15:0] data;
        logic        we;
        logic [12:0] addr;
        logic [15:0] wdata;
        int          col;
        int          row;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int busy_cycles, writes, bad, first_addr, last_addr, stray;
        bit done, hit;
        logic        v;
        logic [1:0]  c;
        logic [15:0] d;
        logic [7:0]  ctl [3];

        i_cmd_valid = 1'b0;
        i_cmd       = 2'd0;
        i_cmd_data  = 16'd0;
        i_nrst      = 1'b0;

        vecs[0]  = '{2'd2, 16'h0041, 1'b1, 13'h0000, 16'hF041, 1, 0};
        vecs[1]  = '{2'd1, 16'h001E, 1'b0, 13'h0000, 16'hF041, 1, 0};
        vecs[2]  = '{2'd0, 16'h0553, 1'b0, 13'h0000, 16'hF041, 83, 5};
        vecs[3]  = '{2'd2, 16'h0042, 1'b1, 13'h14C5, 16'h1E42, 0, 6};
        vecs[4]  = '{2'd0, 16'h3F7F, 1'b0, 13'h14C5, 16'h1E42, 83, 63};
        vecs[5]  = '{2'd2, 16'h0055, 1'b1, 13'h14FF, 16'h1E55, 0, 0};
        vecs[6]  = '{2'd0, 16'hFF0A, 1'b0, 13'h14FF, 16'h1E55, 10, 63};
        vecs[7]  = '{2'd2, 16'h0000, 1'b1, 13'h02BF, 16'h1E00, 11, 63};
        vecs[8]  = '{2'd0, 16'h8059, 1'b0, 13'h02BF, 16'h1E00, 83, 0};
        vecs[9]  = '{2'd2, 16'hAB7A, 1'b1, 13'h14C0, 16'h1E7A, 0, 1};
        vecs[10] = '{2'd1, 16'hC3A5, 1'b0, 13'h14C0, 16'h1E7A, 0, 1};
        vecs[11] = '{2'd2, 16'h0030, 1'b1, 13'h0001, 16'hA530, 1, 1};

        do_reset("reset");

        // Back-to-back commands, one accepted per edge.
        for (int i = 0; i < 12; i++) begin
            i_cmd_valid = 1'b1;
            i_cmd       = vecs[i].cmd;
            i_cmd_data  = vecs[i].data;
            tick();
            check($sformatf("vec%0d_we", i),    32'(o_cell_we),    32'(vecs[i].we));
            check($sformatf("vec%0d_addr", i),  32'(o_cell_addr),  32'(vecs[i].addr));
            check($sformatf("vec%0d_data", i),  32'(o_cell_data),  32'(vecs[i].wdata));
            check($sformatf("vec%0d_col", i),   32'(o_cursor_col), vecs[i].col);
            check($sformatf("vec%0d_row", i),   32'(o_cursor_row), vecs[i].row);
            check($sformatf("vec%0d_ready", i), 32'(o_cmd_ready),  1);
        end
        i_cmd_valid = 1'b0;
        tick();
        check("idle_we", 32'(o_cell_we), 0);

        // Line feed: cursor move only when control chars are enabled.
        issue(2'd0, 16'h040A);
        issue(2'd2, 16'h000A);
`ifdef TEXT_WRITER_CTRL_CHARS_EN
        check("lf_we",  32'(o_cell_we),    0);
        check("lf_col", 32'(o_cursor_col), 0);
        check("lf_row", 32'(o_cursor_row), 5);
`else
        check("lf_we",   32'(o_cell_we),    1);
        check("lf_addr", 32'(o_cell_addr),  32'h0284);
        check("lf_data", 32'(o_cell_data),  32'hA50A);
        check("lf_col",  32'(o_cursor_col), 11);
        check("lf_row",  32'(o_cursor_row), 4);
`endif

        // Full clear with a PUT_CHAR held valid throughout; it must not be taken.
        issue(2'd1, 16'h0007);
        issue(2'd0, 16'h0203);
        issue(2'd3, 16'h0000);
        i_cmd_valid = 1'b1;
        i_cmd       = 2'd2;
        i_cmd_data  = 16'h0099;
        busy_cycles = 0; writes = 0; bad = 0; first_addr = -1; last_addr = -1; done = 0;
        for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
            if (o_busy) begin
                busy_cycles++;
                if (o_cmd_ready) bad++;
                if (!o_cell_we || o_cell_addr != writes[12:0] || o_cell_data != 16'h0720) bad++;
                if (o_cell_we) begin
                    if (writes == 0) first_addr = int'(o_cell_addr);
                    last_addr = int'(o_cell_addr);
                    writes++;
                end
            end else begin
                done        = 1;
                i_cmd_valid = 1'b0;
            end
            if (!done) tick();
        end
        i_cmd_valid = 1'b0;
        check("clear_done",        32'(done),         1);
        check("clear_busy_cycles", busy_cycles,       5376);
        check("clear_writes",      writes,            5376);
        check("clear_bad_cycles",  bad,               0);
        check("clear_first_addr",  first_addr,        0);
        check("clear_last_addr",   last_addr,         32'h14FF);
        check("clear_ready_after", 32'(o_cmd_ready),  1);
        check("clear_we_after",    32'(o_cell_we),    0);
        check("clear_col_after",   32'(o_cursor_col), 0);
        check("clear_row_after",   32'(o_cursor_row), 0);
        tick();
        check("clear_held_cmd_we", 32'(o_cell_we),    0);
        check("clear_held_col",    32'(o_cursor_col), 0);

        // Reset in the middle of a clear.
        issue(2'd3, 16'h0000);
        hit = 0;
        for (int cyc = 0; cyc < 1200 && !hit; cyc++) begin
            if (o_cell_we && o_cell_addr == 13'd1000) hit = 1;
            else tick();
        end
        check("midclr_reached_1000", 32'(hit), 1);
        #2;
        i_nrst = 1'b0;
        #1;
        check_reset_values("midclr_async");
        tick();
        tick();
        i_nrst = 1'b1;
        stray = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick();
            if (o_cell_we || o_busy || !o_cmd_ready) stray++;
        end
        check("midclr_no_resume", stray, 0);
        issue(2'd2, 16'h0041);
        check("midclr_put_we",   32'(o_cell_we),   1);
        check("midclr_put_addr", 32'(o_cell_addr), 0);
        check("midclr_put_data", 32'(o_cell_data), 32'hF041);

        // Random commands against the model.
        do_reset("rand_reset");
        model_reset();
        ctl[0] = 8'h08; ctl[1] = 8'h0A; ctl[2] = 8'h0D;
        for (int n = 0; n < 400; n++) begin
            v = ($urandom_range(0, 9) < 7);
            c = 2'($urandom_range(0, 2));
            d = 16'($urandom);
            if (c == 2'd2 && $urandom_range(0, 5) == 0) d[7:0] = ctl[$urandom_range(0, 2)];
            if (c == 2'd0 && $urandom_range(0, 3) == 0) d[13:8] = 6'd63;
            i_cmd_valid = v;
            i_cmd       = c;
            i_cmd_data  = d;
            tick();
            model_apply(v, c, d);
            check($sformatf("rand%0d_we", n),    32'(o_cell_we),    32'(m_we));
            check($sformatf("rand%0d_addr", n),  32'(o_cell_addr),  32'(m_addr));
            check($sformatf("rand%0d_data", n),  32'(o_cell_data),  32'(m_data));
            check($sformatf("rand%0d_col", n),   32'(o_cursor_col), m_col);
            check($sformatf("rand%0d_row", n),   32'(o_cursor_row), m_row);
            check($sformatf("rand%0d_ready", n), 32'(o_cmd_ready),  1);
        end
        i_cmd_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
